// File: rtl/key_matrix_scan.sv
// 5-row by 4-column keypad scanner. Column inputs are synchronized, sampled once per
// row dwell, and debounced over DEB_N matching samples for both press and release.
module key_matrix_scan #(
  parameter int SCAN_DIV = 50000,
  parameter int DEB_N    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] K_COL,
  output logic [4:0] K_ROW,
  output logic [4:0] key_code,
  output logic       key_valid,
  output logic       key_down
);

  localparam int            DW         = $clog2(SCAN_DIV);
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [3:0]    DEB        = 4'(DEB_N);

  typedef enum logic [1:0] {SCAN, CONFIRM, HOLD, RELEASE} state_t;

  state_t        state_q;
  logic [3:0]    colMeta_q, colSync_q;
  logic [DW-1:0] dwell_q, dwell_d;
  logic [2:0]    row_q, rowAdv;
  logic [4:0]    kRow_q, kRowAdv;
  logic [4:0]    cand_q, code_q, curCode;
  logic [3:0]    match_q, rel_q;
  logic          valid_q, down_q;
  logic          sample, single, idle;
  logic [1:0]    colIdx;

  always_comb begin
    sample  = (dwell_q == DWELL_LAST);
    dwell_d = sample ? '0 : dwell_q + DW'(1);
    rowAdv  = (row_q == 3'd4) ? 3'd0 : row_q + 3'd1;
    kRowAdv = ~(5'b00001 << rowAdv);
  end

  // Classify the synchronized columns: exactly one low line is a usable key.
  always_comb begin
    single = 1'b1;
    colIdx = 2'd0;
    idle   = (colSync_q == 4'b1111);
    case (colSync_q)
      4'b1110: colIdx = 2'd0;
      4'b1101: colIdx = 2'd1;
      4'b1011: colIdx = 2'd2;
      4'b0111: colIdx = 2'd3;
      default: single = 1'b0;
    endcase
    curCode = {row_q, colIdx};
  end

  // The dwell counter free-runs; the FSM only acts on the sample cycle, and
  // the row register only moves when no key is being tracked.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= SCAN;
      colMeta_q <= 4'b1111;
      colSync_q <= 4'b1111;
      dwell_q   <= '0;
      row_q     <= 3'd0;
      kRow_q    <= 5'b11110;
      cand_q    <= 5'd0;
      code_q    <= 5'd0;
      match_q   <= 4'd0;
      rel_q     <= 4'd0;
      valid_q   <= 1'b0;
      down_q    <= 1'b0;
    end else begin
      colMeta_q <= K_COL;
      colSync_q <= colMeta_q;
      dwell_q   <= dwell_d;
      valid_q   <= 1'b0;
      if (sample) begin
        case (state_q)
          SCAN: begin
            if (single) begin
              cand_q <= curCode;
              if (DEB == 4'd1) begin
                code_q  <= curCode;
                valid_q <= 1'b1;
                down_q  <= 1'b1;
                match_q <= 4'd0;
                state_q <= HOLD;
              end else begin
                match_q <= 4'd1;
                state_q <= CONFIRM;
              end
            end else begin
              row_q  <= rowAdv;
              kRow_q <= kRowAdv;
            end
          end
          CONFIRM: begin
            if (single && (curCode == cand_q)) begin
              if ((match_q + 4'd1) == DEB) begin
                code_q  <= cand_q;
                valid_q <= 1'b1;
                down_q  <= 1'b1;
                match_q <= 4'd0;
                state_q <= HOLD;
              end else begin
                match_q <= match_q + 4'd1;
              end
            end else begin
              match_q <= 4'd0;
              state_q <= SCAN;
              row_q   <= rowAdv;
              kRow_q  <= kRowAdv;
            end
          end
          HOLD: begin
            if (idle) begin
              if (DEB == 4'd1) begin
                down_q  <= 1'b0;
                rel_q   <= 4'd0;
                state_q <= SCAN;
                row_q   <= rowAdv;
                kRow_q  <= kRowAdv;
              end else begin
                rel_q   <= 4'd1;
                state_q <= RELEASE;
              end
            end
          end
          RELEASE: begin
            if (idle) begin
              if ((rel_q + 4'd1) == DEB) begin
                down_q  <= 1'b0;
                rel_q   <= 4'd0;
                state_q <= SCAN;
                row_q   <= rowAdv;
                kRow_q  <= kRowAdv;
              end else begin
                rel_q <= rel_q + 4'd1;
              end
            end else begin
              rel_q   <= 4'd0;
              state_q <= HOLD;
            end
          end
          default: state_q <= SCAN;
        endcase
      end
    end
  end

  assign K_ROW     = kRow_q;
  assign key_code  = code_q;
  assign key_valid = valid_q;
  assign key_down  = down_q;

endmodule

// File: tb/tb_key_matrix_scan.sv
// Bench for key_matrix_scan: a physical keypad model drives K_COL from K_ROW, and a
// per-sample reference model of the debounce rules predicts the outputs.
module tb_key_matrix_scan;

  localparam int SCAN_DIV = 8;
  localparam int DEB_N    = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  kCol;
  logic [4:0]  kRow;
  logic [4:0]  keyCode;
  logic        keyValid;
  logic        keyDown;
  logic [19:0] pressed = '0;
  logic [11:0] obsVec;

  int testsRun = 0;
  int testsFailed = 0;
  int obsValid = 0;
  int expValid = 0;

  int mRow, mCand, mMatch, mRel, mCode;
  bit mHeld, mPending, mPulse;

  key_matrix_scan #(.SCAN_DIV(SCAN_DIV), .DEB_N(DEB_N)) dut (
    .clk(clk), .rst(rst), .K_COL(kCol), .K_ROW(kRow),
    .key_code(keyCode), .key_valid(keyValid), .key_down(keyDown)
  );

  always #5 clk = ~clk;

  assign obsVec = {kRow, keyCode, keyValid, keyDown};

  // Keypad switches: a pressed key pulls its column low while its row is driven low.
  always_comb begin
    kCol = 4'b1111;
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 4; c++)
        if (!kRow[r] && pressed[r*4+c]) kCol[c] = 1'b0;
  end

  always @(negedge clk) if (keyValid === 1'b1) obsValid++;

  task automatic modelReset();
    mRow = 0; mCand = 0; mMatch = 0; mRel = 0; mCode = 0;
    mHeld = 0; mPending = 0; mPulse = 0;
  endtask

  // One dwell sample of the debounce rules, seen through the keys on the current row.
  task automatic modelSample();
    int n, col;
    n = 0; col = 0;
    for (int c = 0; c < 4; c++)
      if (pressed[mRow*4+c]) begin n++; col = c; end
    mPulse = 0;
    if (!mHeld) begin
      if (n == 1 && (!mPending || (mRow*4 + col) == mCand)) begin
        if (!mPending) begin mPending = 1; mCand = mRow*4 + col; mMatch = 1; end
        else mMatch++;
        if (mMatch == DEB_N) begin
          mHeld = 1; mPending = 0; mCode = mCand; mPulse = 1; expValid++;
        end
      end else begin
        mPending = 0; mRow = (mRow + 1) % 5;
      end
    end else if (n == 0) begin
      mRel++;
      if (mRel == DEB_N) begin mHeld = 0; mRel = 0; mRow = (mRow + 1) % 5; end
    end else begin
      mRel = 0;
    end
  endtask

  function automatic logic [11:0] expVec();
    logic [4:0] r;
    r = 5'b11111;
    r[mRow] = 1'b0;
    return {r, 5'(mCode), mPulse, mHeld};
  endfunction

  task automatic doReset();
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    @(negedge clk) rst = 1'b0;
    modelReset();
  endtask

  task automatic tickSample();
    repeat (SCAN_DIV) @(posedge clk);
    #1;
    modelSample();
  endtask

  task automatic test_reset();
    pressed = '0;
    doReset();
    testsRun++;
    if (obsVec !== 12'b11110_00000_0_0) begin
      testsFailed++;
      $display("[TB] FAIL reset_outputs: got %b expected %b", obsVec, 12'b11110_00000_0_0);
    end
    repeat (SCAN_DIV - 1) @(posedge clk);
    #1;
    testsRun++;
    if (kRow !== 5'b11110) begin
      testsFailed++;
      $display("[TB] FAIL reset_row_dwell: got %b expected %b", kRow, 5'b11110);
    end
  endtask

  task automatic test_idle();
    int v0;
    pressed = '0;
    doReset();
    v0 = obsValid;
    for (int i = 0; i < 12; i++) begin
      tickSample();
      testsRun++;
      if (obsVec !== expVec()) begin
        testsFailed++;
        $display("[TB] FAIL idle_sample%0d: got %b expected %b", i, obsVec, expVec());
      end
    end
    testsRun++;
    if (obsValid - v0 !== 0) begin
      testsFailed++;
      $display("[TB] FAIL idle_pulses: got %0d expected 0", obsValid - v0);
    end
  endtask

  task automatic test_press();
    int v0;
    pressed = '0;
    doReset();
    v0 = obsValid;
    pressed = 20'd1 << 9;
    for (int i = 0; i < 14; i++) begin
      tickSample();
      testsRun++;
      if (obsVec !== expVec()) begin
        testsFailed++;
        $display("[TB] FAIL press_sample%0d: got %b expected %b", i, obsVec, expVec());
      end
    end
    testsRun++;
    if ({kRow, keyCode, keyDown} !== {5'b11011, 5'd9, 1'b1} || obsValid - v0 !== 1) begin
      testsFailed++;
      $display("[TB] FAIL press_final: got row=%b code=%0d down=%b pulses=%0d expected row=11011 code=9 down=1 pulses=1",
               kRow, keyCode, keyDown, obsValid - v0);
    end
  endtask

  task automatic test_bounce();
    int v0, phase;
    pressed = '0;
    doReset();
    v0 = obsValid;
    phase = 0;
    pressed = 20'd1 << 12;
    for (int i = 0; i < 22; i++) begin
      tickSample();
      testsRun++;
      if (obsVec !== expVec()) begin
        testsFailed++;
        $display("[TB] FAIL bounce_sample%0d: got %b expected %b", i, obsVec, expVec());
      end
      if (phase == 0 && mPending && mMatch == 2) begin pressed = '0; phase = 1; end
      else if (phase == 1) begin pressed = 20'd1 << 12; phase = 2; end
    end
    testsRun++;
    if ({keyCode, keyDown} !== {5'd12, 1'b1} || obsValid - v0 !== 1 || phase != 2) begin
      testsFailed++;
      $display("[TB] FAIL bounce_final: got code=%0d down=%b pulses=%0d phase=%0d expected code=12 down=1 pulses=1 phase=2",
               keyCode, keyDown, obsValid - v0, phase);
    end
  endtask

  task automatic test_release_glitch();
    int v0, key;
    bit seqPress [5] = '{0, 1, 0, 0, 0};
    bit seqDown [5] = '{1, 1, 1, 1, 0};
    pressed = '0;
    doReset();
    v0 = obsValid;
    key = $urandom_range(19);
    pressed = 20'd1 << key;
    for (int i = 0; i < 20 && !mHeld; i++) begin
      tickSample();
      testsRun++;
      if (obsVec !== expVec()) begin
        testsFailed++;
        $display("[TB] FAIL glitch_press%0d: got %b expected %b", i, obsVec, expVec());
      end
    end
    if (!mHeld) begin
      testsFailed++;
      $display("[TB] FAIL glitch_hold_timeout: got no hold expected hold for key %0d", key);
    end
    for (int i = 0; i < 5; i++) begin
      pressed = seqPress[i] ? (20'd1 << key) : '0;
      tickSample();
      testsRun++;
      if (obsVec !== expVec() || keyDown !== seqDown[i]) begin
        testsFailed++;
        $display("[TB] FAIL glitch_release%0d: got %b expected %b down %b", i, obsVec, expVec(), seqDown[i]);
      end
    end
    testsRun++;
    if (obsValid - v0 !== 1 || keyCode !== 5'(key)) begin
      testsFailed++;
      $display("[TB] FAIL glitch_final: got pulses=%0d code=%0d expected pulses=1 code=%0d",
               obsValid - v0, keyCode, key);
    end
  endtask

  task automatic test_multi();
    int v0;
    pressed = '0;
    doReset();
    v0 = obsValid;
    pressed = (20'd1 << 4) | (20'd1 << 6);
    for (int i = 0; i < 15; i++) begin
      tickSample();
      testsRun++;
      if (obsVec !== expVec()) begin
        testsFailed++;
        $display("[TB] FAIL multi_sample%0d: got %b expected %b", i, obsVec, expVec());
      end
    end
    testsRun++;
    if (obsValid - v0 !== 0 || kRow !== 5'b11110) begin
      testsFailed++;
      $display("[TB] FAIL multi_final: got pulses=%0d row=%b expected pulses=0 row=11110", obsValid - v0, kRow);
    end
  endtask

  task automatic test_reset_abort();
    int v0, key;
    for (int mode = 0; mode < 2; mode++) begin
      pressed = '0;
      doReset();
      v0 = obsValid;
      key = $urandom_range(19);
      pressed = 20'd1 << key;
      for (int i = 0; i < 20; i++) begin
        if (mode == 0 && mPending && mMatch == 2) break;
        if (mode == 1 && mHeld) break;
        tickSample();
      end
      v0 = (mode == 1) ? v0 + 1 : v0;
      doReset();
      pressed = '0;
      testsRun++;
      if (obsVec !== 12'b11110_00000_0_0) begin
        testsFailed++;
        $display("[TB] FAIL abort%0d_outputs: got %b expected %b", mode, obsVec, 12'b11110_00000_0_0);
      end
      for (int i = 0; i < 6; i++) begin
        tickSample();
        testsRun++;
        if (obsVec !== expVec()) begin
          testsFailed++;
          $display("[TB] FAIL abort%0d_sample%0d: got %b expected %b", mode, i, obsVec, expVec());
        end
      end
      testsRun++;
      if (obsValid - v0 !== 0) begin
        testsFailed++;
        $display("[TB] FAIL abort%0d_pulses: got %0d expected 0", mode, obsValid - v0);
      end
    end
  endtask

  task automatic test_random();
    int r;
    pressed = '0;
    doReset();
    for (int i = 0; i < 250; i++) begin
      tickSample();
      testsRun++;
      if (obsVec !== expVec()) begin
        testsFailed++;
        $display("[TB] FAIL random_sample%0d: got %b expected %b", i, obsVec, expVec());
      end
      r = $urandom_range(9);
      if (r == 4 || r == 5) pressed = '0;
      else if (r >= 6 && r <= 8) pressed = 20'd1 << $urandom_range(19);
      else if (r == 9) pressed = (20'd1 << $urandom_range(19)) | (20'd1 << $urandom_range(19));
    end
    @(negedge clk);
    testsRun++;
    if (obsValid !== expValid) begin
      testsFailed++;
      $display("[TB] FAIL total_pulses: got %0d expected %0d", obsValid, expValid);
    end
  endtask

  initial begin
    modelReset();
    test_reset();
    test_idle();
    test_press();
    test_bounce();
    test_release_glitch();
    test_multi();
    test_reset_abort();
    test_random();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
